// File: rtl/udp_axis_frame_buf_if.sv
// AXI4-Stream link carrying buffered frames from the frame buffer to the MAC.
interface udp_axis_frame_buf_if #(
    parameter int DATA_WIDTH = 64
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tvalid;
    logic                    tlast;
    logic                    tready;

    modport master (output tdata, tkeep, tvalid, tlast, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/udp_axis_frame_buf.sv
// Store-and-forward buffer: accepts un-throttled frames, exposes only complete
// frames on AXI4-Stream, drops (and counts) any frame that does not fit.
module udp_axis_frame_buf #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 256,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  s_rst_i,
    input  logic                  data_valid_i,
    input  logic                  frame_end_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    udp_axis_frame_buf_if.master  m_axis,
    output logic [CNT_WIDTH-1:0]  frame_cnt_o,
    output logic [CNT_WIDTH-1:0]  drop_cnt_o,
    output logic                  overflow_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_FRAME,
        WR_DROP
    } wr_state_t;

    wr_state_t              state_q, state_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          commit_ptr_q, commit_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]   frame_cnt_q, frame_cnt_d;
    logic [CNT_WIDTH-1:0]   drop_cnt_q, drop_cnt_d;
    logic                   overflow_q, overflow_d;
    logic [DATA_WIDTH-1:0]  tdata_q, tdata_d;
    logic                   tlast_q, tlast_d;
    logic                   tvalid_q, tvalid_d;

    // Each entry is {last, data}; read asynchronously into the output register.
    logic [DATA_WIDTH:0]    mem_q [DEPTH];
    logic                   mem_we;
    logic [DATA_WIDTH:0]    rd_word;
    logic                   full;
    logic                   load;

    // Occupancy is measured against rd_ptr, so a same-cycle read frees nothing.
    assign full    = (wr_ptr_q - rd_ptr_q) == DEPTH_P;
    assign rd_word = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        frame_cnt_d  = frame_cnt_q;
        drop_cnt_d   = drop_cnt_q;
        overflow_d   = 1'b0;
        mem_we       = 1'b0;
        case (state_q)
            WR_IDLE, WR_FRAME: begin
                if (data_valid_i) begin
                    if (!full) begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + PW'(1);
                        state_d  = WR_FRAME;
                        if (frame_end_i) begin
                            commit_ptr_d = wr_ptr_q + PW'(1);
                            frame_cnt_d  = frame_cnt_q + CNT_WIDTH'(1);
                            state_d      = WR_IDLE;
                        end
                    end else begin
                        // Rewind to the last committed frame; the rest of this
                        // frame is swallowed in WR_DROP.
                        wr_ptr_d   = commit_ptr_q;
                        drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
                        overflow_d = 1'b1;
                        state_d    = frame_end_i ? WR_IDLE : WR_DROP;
                    end
                end
            end
            WR_DROP: begin
                if (data_valid_i && frame_end_i) begin
                    state_d = WR_IDLE;
                end
            end
            default: state_d = WR_IDLE;
        endcase
    end

    always_comb begin
        tdata_d  = tdata_q;
        tlast_d  = tlast_q;
        tvalid_d = tvalid_q;
        rd_ptr_d = rd_ptr_q;
        load     = (rd_ptr_q != commit_ptr_q) && (!tvalid_q || m_axis.tready);
        if (load) begin
            tdata_d  = rd_word[DATA_WIDTH-1:0];
            tlast_d  = rd_word[DATA_WIDTH];
            tvalid_d = 1'b1;
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else if (m_axis.tready) begin
            tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {frame_end_i, data_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (s_rst_i) begin
            state_q      <= WR_IDLE;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            frame_cnt_q  <= '0;
            drop_cnt_q   <= '0;
            overflow_q   <= 1'b0;
            tdata_q      <= '0;
            tlast_q      <= 1'b0;
            tvalid_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            frame_cnt_q  <= frame_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            overflow_q   <= overflow_d;
            tdata_q      <= tdata_d;
            tlast_q      <= tlast_d;
            tvalid_q     <= tvalid_d;
        end
    end

    assign m_axis.tdata  = tdata_q;
    assign m_axis.tkeep  = '1;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;
    assign frame_cnt_o   = frame_cnt_q;
    assign drop_cnt_o    = drop_cnt_q;
    assign overflow_o    = overflow_q;
endmodule

// File: tb/tb_udp_axis_frame_buf.sv
// Directed bench for udp_axis_frame_buf: a table of frame scenarios replayed
// through one runner, with a queue of expected beats checked on every handshake.
module tb_udp_axis_frame_buf;
    logic        clk;
    logic        s_rst;
    logic        dv;
    logic        fe;
    logic [63:0] din;
    logic [15:0] frame_cnt;
    logic [15:0] drop_cnt;
    logic        ovf;

    udp_axis_frame_buf_if #(.DATA_WIDTH(64)) ax ();

    udp_axis_frame_buf #(.DATA_WIDTH(64), .DEPTH(256), .CNT_WIDTH(16)) dut (
        .clk_i(clk), .s_rst_i(s_rst), .data_valid_i(dv), .frame_end_i(fe),
        .data_i(din), .m_axis(ax.master), .frame_cnt_o(frame_cnt),
        .drop_cnt_o(drop_cnt), .overflow_o(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0][15:0] lens;   // 0 = no frame in that slot
        logic [3:0]       mask;   // which frames must come out
        logic [1:0]       mode;   // 0 ready=1, 1 alternating, 2 held low while sending
        logic [7:0]       pre;    // partial words before a mid-frame reset
        logic             lat;    // check first-beat latency
        logic [15:0]      fcnt;
        logic [15:0]      dcnt;
        logic [3:0]       novf;
        logic [15:0]      beats;
        logic [3:0]       lasts;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_beats, n_lasts, n_ovf;
    int          tr_mode = 0;
    bit          mon_en  = 0;
    bit          stall_pend = 0;
    logic [63:0] stall_data;
    logic        stall_last;
    logic [64:0] exp_q [$];
    vec_t        vecs [6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (stall_pend) begin
                chk("stall_valid", 64'(ax.tvalid), 64'd1);
                chk("stall_data", ax.tdata, stall_data);
                chk("stall_last", 64'(ax.tlast), 64'(stall_last));
            end
            if (ax.tvalid) chk("tkeep", 64'(ax.tkeep), 64'hFF);
            stall_pend = ax.tvalid && !ax.tready;
            stall_data = ax.tdata;
            stall_last = ax.tlast;
            if (ax.tvalid && ax.tready) begin
                n_beats++;
                if (ax.tlast) n_lasts++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL extra_beat: got data %0h with nothing expected", ax.tdata);
                end else begin
                    logic [64:0] e;
                    e = exp_q.pop_front();
                    chk("beat_data", ax.tdata, e[63:0]);
                    chk("beat_last", 64'(ax.tlast), 64'(e[64]));
                end
            end
        end
        if (ovf) n_ovf++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (tr_mode == 1) ax.tready = ~ax.tready;
    endtask

    task automatic do_reset();
        s_rst = 1'b1;
        dv    = 1'b0;
        fe    = 1'b0;
        tick();
        s_rst = 1'b0;
        chk("rst_tvalid", 64'(ax.tvalid), 64'd0);
        chk("rst_tlast", 64'(ax.tlast), 64'd0);
        chk("rst_tdata", ax.tdata, 64'd0);
        chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        chk("rst_overflow", 64'(ovf), 64'd0);
    endtask

    task automatic send_frame(input int id, input int len, input bit with_end);
        for (int i = 0; i < len; i++) begin
            dv  = 1'b1;
            din = (64'(id) << 32) | 64'(i);
            fe  = with_end && (i == len - 1);
            tick();
        end
        dv = 1'b0;
        fe = 1'b0;
    endtask

    function automatic vec_t mk(input int l0, l1, l2, l3, input logic [3:0] m,
                                input int mode, pre, lat, fc, dc, ov, b, l);
        vec_t v;
        v.lens[0] = 16'(l0); v.lens[1] = 16'(l1);
        v.lens[2] = 16'(l2); v.lens[3] = 16'(l3);
        v.mask  = m;
        v.mode  = 2'(mode);
        v.pre   = 8'(pre);
        v.lat   = lat[0];
        v.fcnt  = 16'(fc);
        v.dcnt  = 16'(dc);
        v.novf  = 4'(ov);
        v.beats = 16'(b);
        v.lasts = 4'(l);
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        int t;
        mon_en    = 0;
        tr_mode   = 0;
        ax.tready = (v.mode != 2'd2);
        do_reset();
        if (v.pre != 0) begin
            // Buffer a stalled frame plus a partial one, then reset over both.
            ax.tready = 1'b0;
            send_frame(7, 5, 1'b1);
            send_frame(7, int'(v.pre), 1'b0);
            tick();
            chk("pre_frame_cnt", 64'(frame_cnt), 64'd1);
            chk("pre_tvalid", 64'(ax.tvalid), 64'd1);
            do_reset();
            ax.tready = 1'b1;
        end
        exp_q.delete();
        for (int f = 0; f < 4; f++) begin
            if (v.lens[f] != 0 && v.mask[f]) begin
                for (int i = 0; i < int'(v.lens[f]); i++) begin
                    exp_q.push_back({(i == int'(v.lens[f]) - 1), (64'(f) << 32) | 64'(i)});
                end
            end
        end
        n_beats    = 0;
        n_lasts    = 0;
        n_ovf      = 0;
        stall_pend = 0;
        mon_en     = 1;
        tr_mode    = (v.mode == 2'd1) ? 1 : 0;
        for (int f = 0; f < 4; f++) begin
            if (v.lens[f] != 0) begin
                send_frame(f, int'(v.lens[f]), 1'b1);
                if (f == 0 && v.lat) begin
                    chk($sformatf("v%0d_lat_edgeN", idx), 64'(ax.tvalid), 64'd0);
                    tick();
                    chk($sformatf("v%0d_lat_edgeN1", idx), 64'(ax.tvalid), 64'd1);
                    chk($sformatf("v%0d_lat_data", idx), ax.tdata, 64'd0);
                end
            end
        end
        if (v.mode == 2'd2) ax.tready = 1'b1;
        t = 0;
        while ((n_beats < int'(v.beats) || ax.tvalid) && t < 3000) begin
            tick();
            t++;
        end
        if (t >= 3000) begin
            n_tests++;
            n_fail++;
            $display("FAIL v%0d_drain_timeout: got %0d beats expected %0d", idx, n_beats, v.beats);
        end
        repeat (10) tick();
        chk($sformatf("v%0d_beats", idx), 64'(n_beats), 64'(v.beats));
        chk($sformatf("v%0d_lasts", idx), 64'(n_lasts), 64'(v.lasts));
        chk($sformatf("v%0d_frame_cnt", idx), 64'(frame_cnt), 64'(v.fcnt));
        chk($sformatf("v%0d_drop_cnt", idx), 64'(drop_cnt), 64'(v.dcnt));
        chk($sformatf("v%0d_ovf_pulses", idx), 64'(n_ovf), 64'(v.novf));
        chk($sformatf("v%0d_exp_left", idx), 64'(exp_q.size()), 64'd0);
        mon_en = 0;
    endtask

    initial begin
        s_rst     = 1'b1;
        dv        = 1'b0;
        fe        = 1'b0;
        din       = '0;
        ax.tready = 1'b1;
        //               lens              mask    mode pre lat fc dc ov beats lasts
        vecs[0] = mk(86, 0, 0, 0,   4'b0001, 0, 0,  1,  1, 0, 0, 86,  1);
        vecs[1] = mk(86, 0, 0, 0,   4'b0001, 1, 0,  0,  1, 0, 0, 86,  1);
        vecs[2] = mk(86, 86, 86, 0, 4'b0011, 2, 0,  0,  2, 1, 1, 172, 2);
        vecs[3] = mk(300, 10, 0, 0, 4'b0010, 0, 0,  0,  1, 1, 1, 10,  1);
        vecs[4] = mk(86, 0, 0, 0,   4'b0001, 0, 40, 0,  1, 0, 0, 86,  1);
        vecs[5] = mk(1, 1, 1, 1,    4'b1111, 0, 0,  0,  4, 0, 0, 4,   4);
        repeat (2) tick();
        for (int k = 0; k < 6; k++) run_vec(vecs[k], k);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
